fw_cmd_sequencer: RTL and testbench
===================================

# fw_cmd_sequencer

Command decoder and test-execution sequencer between the AXI command register and the test engines of one firmware IP. Each accepted 32-bit command word is checked against the IP's device ID and decoded by operation code. The block emits one-cycle strobes for each op code and maintains the 32-bit firmware status word. On `OP_CODE_W_EXECUTE` it dispatches exactly one test engine (test 1..4) and tracks it until completion, abort or error.

## Interface
Parameters:
- `FIRMWARE_ID`, 4'h1, device ID matched against cmd_data[31:28] (4'h1/2/4/8).
- `TEST_NUM_LSB`, 14, LSB of the 4-bit test-number field inside the 24-bit execute body (14 for IP1, 12 for IP2).
- `TEST_MASK`, 4'hF, one-hot tests implemented by this IP; other test numbers are errors.
- `TIMEOUT_CYCLES`, 100000000, watchdog limit in clock cycles (used only with the macro, see Configuration).

Ports (clock and reset first):
- fw_axi_clk  in  1  single clock; all logic is on its rising edge.
- fw_rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command word present; accepted in the same cycle, no backpressure.
- cmd_data  in  32  [31:28] device_id, [27:24] op_code, [23:0] body.
- op_strobe  out  16  one-cycle pulse; bit index = op_code of the accepted command.
- cfg_execute  out  24  body of the last dispatched execute; held until the next dispatch.
- test_start  out  4  one-hot one-cycle pulse that starts a test engine.
- test_done  in  4  completion from the engines; only the bit of the running test is observed.
- test_abort  out  1  one-cycle pulse that aborts the running engine.
- busy  out  1  high while a test runs.
- fw_rst_req  out  1  one-cycle firmware soft-reset request.
- fw_status  out  32  status word.

## Operation
- Reset: every output is 0; state is IDLE; the timeout counter is 0.
- Device-ID check: a command with cmd_data[31:28] != FIRMWARE_ID is ignored completely: no strobe and no status change.
- Status bit mapping:
  - Op codes 1..D set status bit (op_code-1).
  - Op code F sets bit 13.
  - Op codes 0 (NOOP) and E set no status bit.
  - Bits 14..17 are test1..test4 done.
  - Bits 18..30 are always 0.
  - Bit 31 is the execute error bit.
- Op code 1, `W_RST_FW`:
  - Clears fw_status, then sets bit 0.
  - Pulses fw_rst_req.
  - If busy, also pulses test_abort and returns to IDLE.
- Op code E, `W_STATUS_FW_CLEAR`: clears all 32 status bits, including bit 31.
- Op code F, `W_EXECUTE`, field tn = body[TEST_NUM_LSB+3:TEST_NUM_LSB]:
  - The command is valid only when tn is one-hot, (tn & TEST_MASK) != 0 and the block is IDLE.
  - Valid: latch cfg_execute, pulse test_start = tn, set status bit 13, go to RUN.
  - Invalid: set bit 31 only; op_strobe[15] does not pulse and state is unchanged.
- FSM states:
  - IDLE -> RUN on a valid execute.
  - RUN -> IDLE when test_done[running] = 1; set status bit 14 + log2(tn).
  - RUN -> IDLE on `W_RST_FW`, or on timeout when enabled.
- Non-execute commands are accepted in both states.

## Timing
- Command accepted at cycle k: op_strobe, fw_rst_req, test_start and the status update are all registered and visible at k+1.
- busy rises at k+1 for a valid execute.
- test_done sampled high at cycle m: busy falls and the done bit is set at m+1. A new execute is accepted from m+1.
- test_done is not observed in the start cycle k+1.
- Simultaneous events in one cycle:
  - `W_STATUS_FW_CLEAR` with test_done: the clear applies first, then the done bit sets.
  - `W_RST_FW` with test_done: the reset wins; no done bit, and test_abort pulses.
  - `W_RST_FW` with timeout expiry: the reset wins; bit 31 is not set.
- fw_rst_n asserted mid-test: all state clears asynchronously; no test_abort pulse is generated.

## Configuration
- `CMS_PIX28_EXEC_TIMEOUT_EN` defined:
  - A 32-bit counter clears on RUN entry and increments each RUN cycle.
  - When it reaches TIMEOUT_CYCLES-1 without done: pulse test_abort, set bit 31, go to IDLE. All of this is visible in the following cycle.
- Macro undefined: no counter. RUN exits only on test_done, `W_RST_FW` or reset.

## Test plan
- FIRMWARE_ID=1. cmd_data=32'h1F00_4000 (tn=1) -> test_start=4'b0001 at k+1, busy=1, fw_status=32'h0000_2000. Then test_done[0]=1 -> busy=0 and fw_status=32'h0000_6000 next cycle.
- cmd_data=32'h2F00_4000 (wrong device ID) -> no strobe; fw_status unchanged.
- Execute with tn=4'b0011, then tn=4'b0010 while busy -> bit 31 set, no test_start, busy unchanged. Follow with 32'h1E00_0000 -> fw_status=0.
- Running test1, send 32'h1100_0000 -> test_abort and fw_rst_req pulse, busy=0, fw_status=32'h0000_0001.
- Macro on, TIMEOUT_CYCLES=16, test_done held 0 -> test_abort and bit 31 exactly 16 cycles after busy rises.
- `W_STATUS_FW_CLEAR` in the same cycle as test_done[1] for test2 -> fw_status=32'h0000_8000.

Source files
------------

// File: rtl/fw_cmd_sequencer.sv
// Firmware command decoder and single-engine test sequencer with status word.
// Optional execute watchdog enabled by defining CMS_PIX28_EXEC_TIMEOUT_EN.
module fw_cmd_sequencer #(
    parameter logic [3:0]  FIRMWARE_ID    = 4'h1,
    parameter int unsigned TEST_NUM_LSB   = 14,
    parameter logic [3:0]  TEST_MASK      = 4'hF,
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic        fw_axi_clk,
    input  logic        fw_rst_n,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_data,
    output logic [15:0] op_strobe,
    output logic [23:0] cfg_execute,
    output logic [3:0]  test_start,
    input  logic [3:0]  test_done,
    output logic        test_abort,
    output logic        busy,
    output logic        fw_rst_req,
    output logic [31:0] fw_status
);

    localparam int unsigned BODY_W      = 24;
    localparam int unsigned TEST_W      = 4;
    localparam int unsigned STATUS_W    = 32;
    localparam int unsigned ST_EXEC_BIT = 13;
    localparam int unsigned ST_DONE_LSB = 14;
    localparam int unsigned ST_ERR_BIT  = 31;

    localparam logic [3:0] OP_W_RST_FW          = 4'h1;
    localparam logic [3:0] OP_W_STATUS_FW_CLEAR = 4'hE;
    localparam logic [3:0] OP_W_EXECUTE         = 4'hF;

    typedef struct packed {
        logic [3:0]        device_id;
        logic [3:0]        op_code;
        logic [BODY_W-1:0] body;
    } cmd_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [TEST_W-1:0]   run_tn, run_tn_n;
    logic [15:0]         op_strobe_n;
    logic [BODY_W-1:0]   cfg_execute_n;
    logic [TEST_W-1:0]   test_start_n;
    logic                test_abort_n;
    logic                fw_rst_req_n;
    logic [STATUS_W-1:0] fw_status_n;

    cmd_t              cmd_c;
    logic              accept_c;
    logic [TEST_W-1:0] tn_c;
    logic              tn_ok_c;
    logic              exec_ok_c;
    logic              rst_cmd_c;
    logic              done_hit_c;
    logic              to_hit_c;

    assign cmd_c      = cmd_t'(cmd_data);
    assign accept_c   = cmd_valid && (cmd_c.device_id == FIRMWARE_ID);
    assign tn_c       = cmd_c.body[TEST_NUM_LSB +: TEST_W];
    assign tn_ok_c    = (tn_c != '0) && ((tn_c & (tn_c - TEST_W'(1))) == '0)
                        && ((tn_c & TEST_MASK) != '0);
    assign exec_ok_c  = accept_c && (cmd_c.op_code == OP_W_EXECUTE) && tn_ok_c
                        && (state == ST_IDLE);
    assign rst_cmd_c  = accept_c && (cmd_c.op_code == OP_W_RST_FW);
    // test_start is high only in the first RUN cycle, where done is ignored
    assign done_hit_c = (state == ST_RUN) && (test_start == '0)
                        && ((test_done & run_tn) != '0);

`ifdef CMS_PIX28_EXEC_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] to_cnt, to_cnt_n;

    // Watchdog counter: held at zero in IDLE, counts every RUN cycle
    always_comb begin
        to_cnt_n = '0;
        if (state == ST_RUN) begin
            to_cnt_n = to_cnt + 32'd1;
        end
    end

    always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt_n;
        end
    end

    assign to_hit_c = (state == ST_RUN) && (to_cnt == TO_LAST) && !done_hit_c;
`else
    assign to_hit_c = 1'b0;
`endif

    // Next-state, strobe and status computation
    always_comb begin
        state_n       = state;
        run_tn_n      = run_tn;
        op_strobe_n   = '0;
        cfg_execute_n = cfg_execute;
        test_start_n  = '0;
        test_abort_n  = 1'b0;
        fw_rst_req_n  = 1'b0;
        fw_status_n   = fw_status;

        if (accept_c) begin
            case (cmd_c.op_code)
                4'h0: begin
                    op_strobe_n[cmd_c.op_code] = 1'b1;
                end
                OP_W_RST_FW: begin
                    op_strobe_n[cmd_c.op_code] = 1'b1;
                    fw_status_n                = STATUS_W'(1);
                    fw_rst_req_n               = 1'b1;
                end
                OP_W_STATUS_FW_CLEAR: begin
                    op_strobe_n[cmd_c.op_code] = 1'b1;
                    fw_status_n                = '0;
                end
                OP_W_EXECUTE: begin
                    if (exec_ok_c) begin
                        op_strobe_n[cmd_c.op_code] = 1'b1;
                        fw_status_n[ST_EXEC_BIT]   = 1'b1;
                        cfg_execute_n              = cmd_c.body;
                        test_start_n               = tn_c;
                        run_tn_n                   = tn_c;
                    end else begin
                        fw_status_n[ST_ERR_BIT] = 1'b1;
                    end
                end
                default: begin
                    op_strobe_n[cmd_c.op_code]              = 1'b1;
                    fw_status_n[5'(cmd_c.op_code - 4'd1)]   = 1'b1;
                end
            endcase
        end

        case (state)
            ST_IDLE: begin
                if (exec_ok_c) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                // Soft reset outranks both completion and watchdog expiry
                if (rst_cmd_c) begin
                    test_abort_n = 1'b1;
                    state_n      = ST_IDLE;
                end else if (done_hit_c) begin
                    fw_status_n[ST_DONE_LSB +: TEST_W] =
                        fw_status_n[ST_DONE_LSB +: TEST_W] | run_tn;
                    state_n = ST_IDLE;
                end else if (to_hit_c) begin
                    test_abort_n            = 1'b1;
                    fw_status_n[ST_ERR_BIT] = 1'b1;
                    state_n                 = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            state       <= ST_IDLE;
            run_tn      <= '0;
            op_strobe   <= '0;
            cfg_execute <= '0;
            test_start  <= '0;
            test_abort  <= 1'b0;
            busy        <= 1'b0;
            fw_rst_req  <= 1'b0;
            fw_status   <= '0;
        end else begin
            state       <= state_n;
            run_tn      <= run_tn_n;
            op_strobe   <= op_strobe_n;
            cfg_execute <= cfg_execute_n;
            test_start  <= test_start_n;
            test_abort  <= test_abort_n;
            busy        <= (state_n == ST_RUN);
            fw_rst_req  <= fw_rst_req_n;
            fw_status   <= fw_status_n;
        end
    end

endmodule

// File: tb/tb_fw_cmd_sequencer.sv
// Directed self-checking bench for fw_cmd_sequencer (default build, watchdog off).
module tb_fw_cmd_sequencer;

    logic        fw_axi_clk;
    logic        fw_rst_n;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic [15:0] op_strobe;
    logic [23:0] cfg_execute;
    logic [3:0]  test_start;
    logic [3:0]  test_done;
    logic        test_abort;
    logic        busy;
    logic        fw_rst_req;
    logic [31:0] fw_status;

    int n_tests;
    int n_fail;

    fw_cmd_sequencer #(
        .FIRMWARE_ID   (4'h1),
        .TEST_NUM_LSB  (14),
        .TEST_MASK     (4'hF),
        .TIMEOUT_CYCLES(100000000)
    ) dut (
        .fw_axi_clk (fw_axi_clk),
        .fw_rst_n   (fw_rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .op_strobe  (op_strobe),
        .cfg_execute(cfg_execute),
        .test_start (test_start),
        .test_done  (test_done),
        .test_abort (test_abort),
        .busy       (busy),
        .fw_rst_req (fw_rst_req),
        .fw_status  (fw_status)
    );

    initial fw_axi_clk = 1'b0;
    always #5 fw_axi_clk = ~fw_axi_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a command for one cycle; returns 1 time unit after the accepting edge
    task automatic send(input logic [31:0] word);
        cmd_valid = 1'b1;
        cmd_data  = word;
        @(posedge fw_axi_clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
    endtask

    task automatic idle_cycle();
        @(posedge fw_axi_clk);
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        fw_rst_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        test_done = '0;
        repeat (3) @(posedge fw_axi_clk);
        #1;
        check("rst_status", fw_status, 32'h0);
        check("rst_strobe", 32'(op_strobe), 32'h0);
        check("rst_start", 32'(test_start), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_abort", 32'(test_abort), 32'h0);
        check("rst_req", 32'(fw_rst_req), 32'h0);
        check("rst_cfg", 32'(cfg_execute), 32'h0);
        fw_rst_n = 1'b1;
        idle_cycle();

        // Test 1 execute and completion
        send(32'h1F00_4000);
        check("t1_start", 32'(test_start), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_status", fw_status, 32'h0000_2000);
        check("t1_strobe", 32'(op_strobe), 32'h8000);
        check("t1_cfg", 32'(cfg_execute), 32'h0000_4000);
        idle_cycle();
        check("t1_start_pulse", 32'(test_start), 32'h0);
        check("t1_strobe_pulse", 32'(op_strobe), 32'h0);
        test_done = 4'b0001;
        idle_cycle();
        test_done = 4'b0000;
        check("t1_done_busy", 32'(busy), 32'h0);
        check("t1_done_status", fw_status, 32'h0000_6000);

        // Foreign device ID is ignored
        send(32'h2F00_4000);
        check("badid_strobe", 32'(op_strobe), 32'h0);
        check("badid_start", 32'(test_start), 32'h0);
        check("badid_status", fw_status, 32'h0000_6000);
        check("badid_busy", 32'(busy), 32'h0);

        send(32'h1E00_0000);
        check("clr_status", fw_status, 32'h0);
        check("clr_strobe", 32'(op_strobe), 32'h4000);

        // Non-one-hot test number
        send(32'h1F00_C000);
        check("multi_status", fw_status, 32'h8000_0000);
        check("multi_start", 32'(test_start), 32'h0);
        check("multi_strobe", 32'(op_strobe), 32'h0);
        check("multi_busy", 32'(busy), 32'h0);
        send(32'h1E00_0000);
        check("clr2_status", fw_status, 32'h0);

        // Test 2 running, second execute refused
        send(32'h1F00_8000);
        check("t2_start", 32'(test_start), 32'h2);
        check("t2_status", fw_status, 32'h0000_2000);
        send(32'h1F00_8000);
        check("busy_exec_status", fw_status, 32'h8000_2000);
        check("busy_exec_start", 32'(test_start), 32'h0);
        check("busy_exec_strobe", 32'(op_strobe), 32'h0);
        check("busy_exec_busy", 32'(busy), 32'h1);
        test_done = 4'b0001;
        idle_cycle();
        test_done = 4'b0000;
        check("wrong_done_busy", 32'(busy), 32'h1);
        // Clear together with completion: done bit survives
        test_done = 4'b0010;
        send(32'h1E00_0000);
        test_done = 4'b0000;
        check("clr_done_status", fw_status, 32'h0000_8000);
        check("clr_done_busy", 32'(busy), 32'h0);

        send(32'h1500_0000);
        check("op5_status", fw_status, 32'h0000_8010);
        check("op5_strobe", 32'(op_strobe), 32'h0020);
        send(32'h1D00_0000);
        check("opd_status", fw_status, 32'h0000_9010);
        check("opd_strobe", 32'(op_strobe), 32'h2000);
        send(32'h1000_0000);
        check("noop_strobe", 32'(op_strobe), 32'h0001);
        check("noop_status", fw_status, 32'h0000_9010);

        // Soft reset while test 1 runs
        send(32'h1F00_4000);
        check("t1b_status", fw_status, 32'h0000_B010);
        send(32'h1100_0000);
        check("rstfw_abort", 32'(test_abort), 32'h1);
        check("rstfw_req", 32'(fw_rst_req), 32'h1);
        check("rstfw_busy", 32'(busy), 32'h0);
        check("rstfw_status", fw_status, 32'h0000_0001);
        check("rstfw_strobe", 32'(op_strobe), 32'h0002);
        idle_cycle();
        check("rstfw_abort_pulse", 32'(test_abort), 32'h0);
        check("rstfw_req_pulse", 32'(fw_rst_req), 32'h0);

        // Done during dispatch and start cycles is ignored
        test_done = 4'b0001;
        send(32'h1F00_4000);
        idle_cycle();
        test_done = 4'b0000;
        check("early_done_busy", 32'(busy), 32'h1);
        check("early_done_status", fw_status, 32'h0000_2001);

        // Soft reset wins over simultaneous completion
        test_done = 4'b0001;
        send(32'h1100_0000);
        test_done = 4'b0000;
        check("rst_vs_done_status", fw_status, 32'h0000_0001);
        check("rst_vs_done_abort", 32'(test_abort), 32'h1);
        check("rst_vs_done_busy", 32'(busy), 32'h0);

        // Test 4 through completion
        send(32'h1F02_0000);
        check("t4_start", 32'(test_start), 32'h8);
        check("t4_cfg", 32'(cfg_execute), 32'h0002_0000);
        idle_cycle();
        test_done = 4'b1000;
        idle_cycle();
        test_done = 4'b0000;
        check("t4_done_status", fw_status, 32'h0002_2001);
        check("t4_done_busy", 32'(busy), 32'h0);

        // Async reset mid-test clears everything without an abort pulse
        send(32'h1F00_8000);
        check("t2b_busy", 32'(busy), 32'h1);
        fw_rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_status", fw_status, 32'h0);
        check("arst_abort", 32'(test_abort), 32'h0);
        check("arst_cfg", 32'(cfg_execute), 32'h0);
        check("arst_start", 32'(test_start), 32'h0);
        idle_cycle();
        check("arst_abort_held", 32'(test_abort), 32'h0);
        fw_rst_n = 1'b1;
        idle_cycle();
        send(32'h1F00_4000);
        check("post_rst_start", 32'(test_start), 32'h1);
        check("post_rst_status", fw_status, 32'h0000_2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
